// File: rtl/quadrature_generator.sv
// Two-phase quadrature synthesiser driven by detent-count commands, with a paddle position model.
// Optional contact bounce on every edge when QGEN_BOUNCE_EN is defined.
module quadrature_generator #(
  parameter int EDGE_CYCLES    = 1000,
  parameter int POS_RESET      = 15,
  parameter int POS_STEP       = 20,
  parameter int POS_HI         = 230,
  parameter int POS_LO         = 20,
  parameter int BOUNCE_TOGGLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_count,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       detent_done,
  output logic [7:0] pos
);

  localparam int DW = (EDGE_CYCLES > 1) ? $clog2(EDGE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(EDGE_CYCLES - 1);
  localparam logic [7:0] POS_RESET8 = 8'(POS_RESET);
  localparam logic [7:0] POS_STEP8  = 8'(POS_STEP);
  localparam logic [7:0] POS_HI8    = 8'(POS_HI);
  localparam logic [7:0] POS_LO8    = 8'(POS_LO);
`ifdef QGEN_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
  localparam logic [DW-1:0] BOUNCE_LAST = DW'(2 * BOUNCE_TOGGLES);
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  if (EDGE_CYCLES < 4 || (BOUNCE_EN && EDGE_CYCLES <= 2 * BOUNCE_TOGGLES + 1)) begin : g_bad_params
    $error("quadrature_generator: EDGE_CYCLES too small for the selected configuration");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [1:0]      phase;
  logic [DW-1:0]   dwell;
  logic [DW-1:0]   dwell_next;
  logic [7:0]      remaining;
  logic            dir;
`ifdef QGEN_BOUNCE_EN
  logic [1:0]      bounce_mask;
`endif

  assign dwell_next = dwell + DW'(1);

  // Phase 3 is the detent-complete 00 state; phases 0..2 are the three non-idle states.
  function automatic logic [1:0] phase_ab(input logic d, input logic [1:0] p);
    logic [1:0] ab;
    case (p)
      2'd0:    ab = d ? 2'b01 : 2'b10;
      2'd1:    ab = 2'b11;
      2'd2:    ab = d ? 2'b10 : 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  function automatic logic [7:0] next_pos(input logic d, input logic [7:0] p);
    logic [7:0] np;
    if (!d) begin
      np = (p < POS_HI8) ? p + POS_STEP8 : p;
    end else begin
      np = (p > POS_LO8) ? p - POS_STEP8 : p;
    end
    return np;
  endfunction

  // Command FSM: accept, phase sequencing, dwell timing, abort and position model.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      phase       <= 2'd0;
      dwell       <= '0;
      remaining   <= 8'd0;
      dir         <= 1'b0;
      a           <= 1'b0;
      b           <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      detent_done <= 1'b0;
      pos         <= POS_RESET8;
`ifdef QGEN_BOUNCE_EN
      bounce_mask <= 2'b00;
`endif
    end else begin
      detent_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_count != 8'd0) begin
            state     <= RUN;
            dir       <= cmd_dir;
            remaining <= cmd_count - 8'd1;
            phase     <= 2'd0;
            dwell     <= '0;
            {a, b}    <= phase_ab(cmd_dir, 2'd0);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef QGEN_BOUNCE_EN
            bounce_mask <= phase_ab(cmd_dir, 2'd0);
`endif
          end
        end
        RUN: begin
          if (dwell != DWELL_LAST) begin
            dwell <= dwell_next;
            if (abort) begin
              remaining <= 8'd0;
            end
`ifdef QGEN_BOUNCE_EN
            // Odd dwell steps inside the bounce window show the old level of the changing line.
            if (dwell_next <= BOUNCE_LAST && dwell_next[0]) begin
              {a, b} <= phase_ab(dir, phase) ^ bounce_mask;
            end else begin
              {a, b} <= phase_ab(dir, phase);
            end
`endif
          end else begin
            dwell <= '0;
            if (phase == 2'd3) begin
              // An abort seen on the last dwell cycle still wins over starting another detent.
              if (abort || remaining == 8'd0) begin
                state     <= IDLE;
                phase     <= 2'd0;
                remaining <= 8'd0;
                {a, b}    <= 2'b00;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end else begin
                remaining <= remaining - 8'd1;
                phase     <= 2'd0;
                {a, b}    <= phase_ab(dir, 2'd0);
`ifdef QGEN_BOUNCE_EN
                bounce_mask <= phase_ab(dir, 2'd0);
`endif
              end
            end else begin
              phase  <= phase + 2'd1;
              {a, b} <= phase_ab(dir, phase + 2'd1);
`ifdef QGEN_BOUNCE_EN
              bounce_mask <= phase_ab(dir, phase) ^ phase_ab(dir, phase + 2'd1);
`endif
              if (phase == 2'd2) begin
                detent_done <= 1'b1;
                pos         <= next_pos(dir, pos);
              end
              if (abort) begin
                remaining <= 8'd0;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          {a, b}    <= 2'b00;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator; detent completions are checked against a queue of expected positions.
module tb_quadrature_generator;

`ifdef QGEN_BOUNCE_EN
  localparam int EC = 10;
  localparam int EXP_TOGGLES = 6;
`else
  localparam int EC = 4;
  localparam int EXP_TOGGLES = 0;
`endif
  localparam int BT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_count = 8'd0;
  logic       abort = 1'b0;
  logic       a, b, busy, detent_done;
  logic [7:0] pos;

  int checks = 0;
  int errors = 0;
  int dd_count = 0;
  logic [7:0] sb[$];
  logic [7:0] mp;

  quadrature_generator #(
    .EDGE_CYCLES(EC), .POS_RESET(15), .POS_STEP(20), .POS_HI(230), .POS_LO(20), .BOUNCE_TOGGLES(BT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_count(cmd_count), .abort(abort), .a(a), .b(b), .busy(busy),
    .detent_done(detent_done), .pos(pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model of the position after each detent, pushed as the stimulus is issued.
  task automatic expect_detents(input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      if (!d) mp = (mp < 8'd230) ? mp + 8'd20 : mp;
      else    mp = (mp > 8'd20)  ? mp - 8'd20 : mp;
      sb.push_back(mp);
    end
  endtask

  // Offer one command; returns in the cycle after the accepting edge.
  task automatic send(input logic d, input logic [7:0] n);
    cmd_valid = 1'b1; cmd_dir = d; cmd_count = n;
    chk("ready_before_accept", cmd_ready, 1'b1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(1);
    rst = 1'b1; tick(1);
    mp = 8'd15;
  endtask

  // Scoreboard side: every completion pulse must match the next expected position.
  always @(negedge clk) begin
    if (rst === 1'b1 && detent_done === 1'b1) begin
      dd_count++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_detent observed pos %0d expected no pulse", pos);
      end else begin
        chk("detent_pos", pos, sb.pop_front());
      end
    end
  end

  initial begin
    int base, ta, tb_;
    logic pa, pb;
    mp = 8'd15;
    tick(1);
    chk("rst_a", a, 1'b0); chk("rst_b", b, 1'b0); chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0); chk("rst_dd", detent_done, 1'b0); chk("rst_pos", pos, 8'd15);
    rst = 1'b1; tick(1);

    // Basic cw detent with exact transition times.
    expect_detents(1'b0, 1);
    base = dd_count;
    send(1'b0, 8'd1);
    chk("cw_ab0", {a, b}, 2'b10); chk("cw_busy", busy, 1'b1); chk("cw_notready", cmd_ready, 1'b0);
    tick(EC); chk("cw_ab1", {a, b}, 2'b11);
    tick(EC); chk("cw_ab2", {a, b}, 2'b01); chk("cw_no_dd_early", detent_done, 1'b0);
    tick(EC); chk("cw_ab3", {a, b}, 2'b00); chk("cw_dd", detent_done, 1'b1); chk("cw_pos", pos, 8'd35);
    tick(1); chk("cw_dd_one_cycle", detent_done, 1'b0);
    tick(EC - 2); chk("cw_ready_late", cmd_ready, 1'b0);
    tick(1); chk("cw_ready", cmd_ready, 1'b1); chk("cw_idle", busy, 1'b0);
    chk("cw_pulses", dd_count - base, 1);

    // Zero-count command.
    send(1'b0, 8'd0);
    chk("zero_ready", cmd_ready, 1'b1); chk("zero_busy", busy, 1'b0);
    tick(EC); chk("zero_ab", {a, b}, 2'b00);

    // Bounce shape on one transition: only the changing line toggles.
    expect_detents(1'b0, 1);
    send(1'b0, 8'd1);
    ta = 0; tb_ = 0; pa = a; pb = b;
    for (int i = 1; i < EC; i++) begin
      tick(1);
      if (a !== pa) ta++;
      if (b !== pb) tb_++;
      pa = a; pb = b;
    end
    chk("bounce_a_toggles", ta, EXP_TOGGLES); chk("bounce_b_toggles", tb_, 0);
    chk("bounce_settled", {a, b}, 2'b10);
    tick(EC); chk("bounce_ab1", {a, b}, 2'b11);
    tick(3 * EC); chk("bounce_done", cmd_ready, 1'b1); chk("bounce_pos", pos, 8'd55);

    // Saturation both ways from reset.
    do_reset();
    base = dd_count;
    expect_detents(1'b0, 12);
    send(1'b0, 8'd12);
    tick(48 * EC - 1); chk("sat_up_busy", cmd_ready, 1'b0);
    tick(1); chk("sat_up_ready", cmd_ready, 1'b1); chk("sat_up_pos", pos, 8'd235);
    chk("sat_up_pulses", dd_count - base, 12);
    expect_detents(1'b1, 12);
    send(1'b1, 8'd12);
    chk("ccw_ab0", {a, b}, 2'b01);
    tick(48 * EC); chk("sat_dn_ready", cmd_ready, 1'b1); chk("sat_dn_pos", pos, 8'd15);
    chk("sat_dn_pulses", dd_count - base, 24);

    // Abort during the second detent.
    base = dd_count;
    expect_detents(1'b0, 2);
    send(1'b0, 8'd5);
    tick(5 * EC + 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(2 * EC - 2);
    chk("abort_ab", {a, b}, 2'b00); chk("abort_dd", detent_done, 1'b1); chk("abort_pos", pos, 8'd55);
    tick(EC - 1); chk("abort_ready_late", cmd_ready, 1'b0);
    tick(1); chk("abort_ready", cmd_ready, 1'b1); chk("abort_ab_idle", {a, b}, 2'b00);
    tick(4 * EC); chk("abort_pulses", dd_count - base, 2); chk("abort_ab_stay", {a, b}, 2'b00);

    // Command held valid while busy; input changes do not affect the running one.
    expect_detents(1'b0, 1);
    expect_detents(1'b1, 1);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_count = 8'd1;
    tick(1);
    cmd_dir = 1'b1;
    chk("b2b_first_ab0", {a, b}, 2'b10);
    tick(EC); chk("b2b_first_ab1", {a, b}, 2'b11);
    tick(3 * EC - 1); chk("b2b_not_ready", cmd_ready, 1'b0);
    tick(1); chk("b2b_ready", cmd_ready, 1'b1); chk("b2b_gap_ab", {a, b}, 2'b00);
    tick(1); cmd_valid = 1'b0;
    chk("b2b_second_ab0", {a, b}, 2'b01); chk("b2b_second_busy", busy, 1'b1);
    tick(4 * EC); chk("b2b_end_ready", cmd_ready, 1'b1); chk("b2b_pos", pos, 8'd55);

    // Reset in the middle of a command.
    base = dd_count;
    send(1'b0, 8'd3);
    tick(EC); chk("mid_ab11", {a, b}, 2'b11);
    #1 rst = 1'b0;
    #1;
    chk("mid_ab", {a, b}, 2'b00); chk("mid_pos", pos, 8'd15); chk("mid_ready", cmd_ready, 1'b1);
    chk("mid_dd", detent_done, 1'b0);
    tick(1); rst = 1'b1; mp = 8'd15;
    tick(4 * EC);
    chk("mid_no_pulse", dd_count - base, 0); chk("mid_idle_ab", {a, b}, 2'b00);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
